// File: rtl/vga_fb_write_ctrl_pkg.sv
// Shared defaults, fill FSM encoding and the framebuffer address-wrap helper
// for the VGA framebuffer write scheduler.
package vga_fb_pkg;

    localparam int unsigned FB_ADDR_W    = 19;
    localparam int unsigned FB_DATA_W    = 8;
    localparam int unsigned FB_DEPTH_DEF = 307200;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_RUN,
        FILL_DONE
    } fill_state_e;

    function automatic logic [31:0] wrap_inc(input logic [31:0] a, input logic [31:0] depth);
        return (a + 32'd1 == depth) ? '0 : a + 32'd1;
    endfunction

endpackage

// File: rtl/vga_fb_write_ctrl_if.sv
// Framebuffer write port: registered address/data/valid towards the RAM,
// ready back from it; a transfer happens when fb_we && fb_ready.
interface vga_fb_write_ctrl_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 8
) ();

    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;
    logic              fb_we;
    logic              fb_ready;

    modport master (output fb_addr, fb_data, fb_we, input fb_ready);
    modport slave  (input fb_addr, fb_data, fb_we, output fb_ready);

endinterface

// File: rtl/vga_fb_write_ctrl_fill.sv
// Rectangle/span fill engine: FSM, wrapping address counter and remaining
// pixel counter, offering one pixel at a time through valid/accept.
module vga_fb_fill
    import vga_fb_pkg::*;
#(
    parameter int unsigned ADDR_W   = FB_ADDR_W,
    parameter int unsigned DATA_W   = FB_DATA_W,
    parameter int unsigned FB_DEPTH = FB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_color,
    input  logic              accept,
    input  logic              xfer,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    fill_state_e       state, state_nxt;
    logic [ADDR_W-1:0] cur, rem;
    logic [DATA_W-1:0] color;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL_IDLE;
        else        state <= state_nxt;
    end

    // Once rem hits 0 the output register holds the last fill pixel, so the
    // next transfer is that pixel.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL_IDLE: if (fill_start) state_nxt = (fill_len != '0) ? FILL_RUN : FILL_DONE;
            FILL_RUN:  if (rem == '0 && xfer) state_nxt = FILL_DONE;
            FILL_DONE: state_nxt = FILL_IDLE;
            default:   state_nxt = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur   <= '0;
            rem   <= '0;
            color <= '0;
        end else if (state == FILL_IDLE && fill_start) begin
            cur   <= (fill_base >= ADDR_W'(FB_DEPTH)) ? fill_base - ADDR_W'(FB_DEPTH) : fill_base;
            rem   <= fill_len;
            color <= fill_color;
        end else if (accept) begin
            cur   <= ADDR_W'(wrap_inc(32'(cur), 32'(FB_DEPTH)));
            rem   <= rem - ADDR_W'(1);
        end
    end

    assign valid = (state == FILL_RUN) && (rem != '0);
    assign addr  = cur;
    assign data  = color;
    assign busy  = (state != FILL_IDLE);
    assign done  = (state == FILL_DONE);

endmodule

// File: rtl/vga_fb_write_ctrl.sv
// VGA framebuffer write scheduler: PIO edge writes (1-entry pend) win over
// the fill engine; the fill engine exists only when VGA_FB_FILL_EN is defined.
module vga_fb_write_ctrl
    import vga_fb_pkg::*;
#(
    parameter int unsigned ADDR_W   = FB_ADDR_W,
    parameter int unsigned DATA_W   = FB_DATA_W,
    parameter int unsigned FB_DEPTH = FB_DEPTH_DEF
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [ADDR_W-1:0]   pio_addr,
    input  logic [DATA_W-1:0]   pio_data,
    input  logic                pio_we,
    input  logic                fill_start,
    input  logic [ADDR_W-1:0]   fill_base,
    input  logic [ADDR_W-1:0]   fill_len,
    input  logic [DATA_W-1:0]   fill_color,
    output logic                fill_busy,
    output logic                fill_done,
    input  logic                ovf_clr,
    output logic                pio_ovf,
    vga_fb_write_ctrl_if.master fb
);

    logic              we_q, pio_edge;
    logic              pend_valid, pend_drain, pend_take, pio_drop;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              out_we, load_ok, xfer;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              fill_valid, fill_accept;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;

    assign pio_edge    = pio_we && !we_q;
    assign load_ok     = !out_we || fb.fb_ready;
    assign xfer        = out_we && fb.fb_ready;
    assign pend_drain  = pend_valid && load_ok;
    assign pend_take   = pio_edge && (!pend_valid || pend_drain);
    assign pio_drop    = pio_edge && pend_valid && !pend_drain;
    assign fill_accept = load_ok && !pend_valid && fill_valid;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            we_q       <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            pio_ovf    <= 1'b0;
        end else begin
            we_q <= pio_we;
            if (pend_take) begin
                pend_valid <= 1'b1;
                pend_addr  <= pio_addr;
                pend_data  <= pio_data;
            end else if (pend_drain) begin
                pend_valid <= 1'b0;
            end
            if (ovf_clr)       pio_ovf <= 1'b0;
            else if (pio_drop) pio_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else if (load_ok) begin
            if (pend_valid) begin
                out_we   <= 1'b1;
                out_addr <= pend_addr;
                out_data <= pend_data;
            end else if (fill_valid) begin
                out_we   <= 1'b1;
                out_addr <= fill_addr;
                out_data <= fill_data;
            end else begin
                out_we   <= 1'b0;
            end
        end
    end

    assign fb.fb_we   = out_we;
    assign fb.fb_addr = out_addr;
    assign fb.fb_data = out_data;

`ifdef VGA_FB_FILL_EN
    vga_fb_fill #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FB_DEPTH (FB_DEPTH)
    ) u_fill (
        .clk        (clk_clk),
        .rst_n      (reset_reset_n),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_color (fill_color),
        .accept     (fill_accept),
        .xfer       (xfer),
        .valid      (fill_valid),
        .addr       (fill_addr),
        .data       (fill_data),
        .busy       (fill_busy),
        .done       (fill_done)
    );
`else
    logic unused_fill;
    assign unused_fill = ^{fill_start, fill_base, fill_len, fill_color, fill_accept, xfer};
    assign fill_valid  = 1'b0;
    assign fill_addr   = '0;
    assign fill_data   = '0;
    assign fill_busy   = 1'b0;
    assign fill_done   = 1'b0;
`endif

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
// Scoreboard bench for vga_fb_write_ctrl; fill scenarios run when
// VGA_FB_FILL_EN is defined, otherwise fill inputs must be ignored.
module tb_vga_fb_write_ctrl;

    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] pio_addr, fill_base, fill_len;
    logic [7:0]  pio_data, fill_color;
    logic        pio_we, fill_start, ovf_clr;
    logic        fill_busy, fill_done, pio_ovf;

    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    int   done_cnt = 0;
    exp_t q[$];

    vga_fb_write_ctrl_if #(.ADDR_W(19), .DATA_W(8)) fb_if ();

    vga_fb_write_ctrl #(.ADDR_W(19), .DATA_W(8), .FB_DEPTH(307200)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .pio_addr      (pio_addr),
        .pio_data      (pio_data),
        .pio_we        (pio_we),
        .fill_start    (fill_start),
        .fill_base     (fill_base),
        .fill_len      (fill_len),
        .fill_color    (fill_color),
        .fill_busy     (fill_busy),
        .fill_done     (fill_done),
        .ovf_clr       (ovf_clr),
        .pio_ovf       (pio_ovf),
        .fb            (fb_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [18:0] a, input logic [7:0] d);
        q.push_back({a, d});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (!fill_done && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (!fill_done) begin
            errors++;
            $display("FAIL fill_done_timeout: got no fill_done within %0d cycles", max_cyc);
        end
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fb_we"},     32'(fb_if.fb_we), 32'd0);
        check({tag, "_fb_addr"},   32'(fb_if.fb_addr), 32'd0);
        check({tag, "_fb_data"},   32'(fb_if.fb_data), 32'd0);
        check({tag, "_fill_busy"}, 32'(fill_busy), 32'd0);
        check({tag, "_fill_done"}, 32'(fill_done), 32'd0);
        check({tag, "_pio_ovf"},   32'(pio_ovf), 32'd0);
    endtask

    // Monitor: every presented word must be the scoreboard head (this also
    // proves stability while stalled); pop on transfer.
    always @(negedge clk) begin
        if (rst_n && fb_if.fb_we) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         fb_if.fb_addr, fb_if.fb_data);
            end else begin
                check("fb_addr", 32'(fb_if.fb_addr), 32'(q[0].a));
                check("fb_data", 32'(fb_if.fb_data), 32'(q[0].d));
                if (fb_if.fb_ready) void'(q.pop_front());
            end
            if (fb_if.fb_ready) xfers++;
        end
        if (rst_n && fill_done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, x0, d0;
        rst_n = 1'b0; pio_addr = '0; pio_data = '0; pio_we = 1'b0;
        fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_color = '0;
        ovf_clr = 1'b0; fb_if.fb_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single PIO write: 2-cycle latency, one cycle of fb_we, no re-trigger while held
        pio_addr = 19'h00010; pio_data = 8'hA5; push(19'h00010, 8'hA5);
        pio_we = 1'b1;
        tick();
        check("pio_lat1_we", 32'(fb_if.fb_we), 32'd0);
        tick();
        check("pio_lat2_we", 32'(fb_if.fb_we), 32'd1);
        check("pio_lat2_addr", 32'(fb_if.fb_addr), 32'h10);
        check("pio_lat2_data", 32'(fb_if.fb_data), 32'hA5);
        tick();
        check("pio_one_cycle_we", 32'(fb_if.fb_we), 32'd0);
        hi = 0;
        repeat (5) begin
            tick();
            if (fb_if.fb_we) hi++;
        end
        check("pio_held_no_rewrite", 32'(hi), 32'd0);
        pio_we = 1'b0;
        tick();

`ifdef VGA_FB_FILL_EN
        // Fill across the end of the framebuffer
        push(19'd307198, 8'h3C); push(19'd307199, 8'h3C);
        push(19'd0, 8'h3C);      push(19'd1, 8'h3C);
        fill_base = 19'd307198; fill_len = 19'd4; fill_color = 8'h3C;
        d0 = done_cnt;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("wrap_busy", 32'(fill_busy), 32'd1);
        check("wrap_first_we", 32'(fb_if.fb_we), 32'd0);
        repeat (4) begin
            tick();
            check("wrap_stream_we", 32'(fb_if.fb_we), 32'd1);
        end
        tick();
        check("wrap_done", 32'(fill_done), 32'd1);
        check("wrap_done_we", 32'(fb_if.fb_we), 32'd0);
        tick();
        check("wrap_done_drop", 32'(fill_done), 32'd0);
        check("wrap_busy_drop", 32'(fill_busy), 32'd0);
        check("wrap_done_count", 32'(done_cnt - d0), 32'd1);
        check("wrap_sb_empty", 32'(q.size()), 32'd0);

        // PIO insertion at the 3rd fill pixel
        push(19'h200, 8'h77); push(19'h201, 8'h77); push(19'h100, 8'h11);
        for (int i = 2; i < 8; i++) push(19'h200 + 19'(i), 8'h77);
        fill_base = 19'h200; fill_len = 19'd8; fill_color = 8'h77;
        pio_addr = 19'h100; pio_data = 8'h11;
        x0 = xfers; d0 = done_cnt;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick();
        pio_we = 1'b1;
        wait_done(40);
        pio_we = 1'b0;
        check("ins_xfer_count", 32'(xfers - x0), 32'd9);
        check("ins_sb_empty", 32'(q.size()), 32'd0);
        check("ins_done_count", 32'(done_cnt - d0), 32'd1);

        // Backpressure for 5 cycles mid-fill
        for (int i = 0; i < 6; i++) push(19'h1000 + 19'(i), 8'hC3);
        fill_base = 19'h1000; fill_len = 19'd6; fill_color = 8'hC3;
        x0 = xfers;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (2) tick();
        fb_if.fb_ready = 1'b0;
        repeat (5) tick();
        check("stall_we_held", 32'(fb_if.fb_we), 32'd1);
        check("stall_busy", 32'(fill_busy), 32'd1);
        fb_if.fb_ready = 1'b1;
        wait_done(40);
        check("stall_xfer_count", 32'(xfers - x0), 32'd6);
        check("stall_sb_empty", 32'(q.size()), 32'd0);

        // Zero-length fill
        x0 = xfers; d0 = done_cnt;
        fill_len = 19'd0;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("len0_done", 32'(fill_done), 32'd1);
        check("len0_busy", 32'(fill_busy), 32'd1);
        check("len0_we", 32'(fb_if.fb_we), 32'd0);
        tick();
        check("len0_done_drop", 32'(fill_done), 32'd0);
        check("len0_busy_drop", 32'(fill_busy), 32'd0);
        check("len0_done_count", 32'(done_cnt - d0), 32'd1);
        check("len0_no_xfer", 32'(xfers - x0), 32'd0);

        // Asynchronous reset mid-fill
        for (int i = 0; i < 10; i++) push(19'h3000 + 19'(i), 8'h5A);
        fill_base = 19'h3000; fill_len = 19'd10; fill_color = 8'h5A;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        d0 = done_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) tick();
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_idle_busy", 32'(fill_busy), 32'd0);
        check("midrst_idle_we", 32'(fb_if.fb_we), 32'd0);
`else
        // Fill engine absent: fill inputs have no effect
        x0 = xfers;
        fill_base = 19'd5; fill_len = 19'd4; fill_color = 8'h3C;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check("nofill_busy", 32'(fill_busy), 32'd0);
        check("nofill_done", 32'(fill_done), 32'd0);
        repeat (6) tick();
        check("nofill_busy_late", 32'(fill_busy), 32'd0);
        check("nofill_no_xfer", 32'(xfers - x0), 32'd0);
`endif

        // Overflow: A stuck in output register, B pending, C dropped
        fb_if.fb_ready = 1'b0;
        push(19'h00A, 8'hA1); push(19'h00B, 8'hB2);
        pio_addr = 19'h00A; pio_data = 8'hA1; pio_we = 1'b1;
        tick();
        pio_we = 1'b0;
        tick();
        pio_addr = 19'h00B; pio_data = 8'hB2; pio_we = 1'b1;
        tick();
        pio_we = 1'b0;
        tick();
        check("ovf_before_drop", 32'(pio_ovf), 32'd0);
        pio_addr = 19'h00C; pio_data = 8'hC3; pio_we = 1'b1;
        tick();
        check("ovf_set", 32'(pio_ovf), 32'd1);
        pio_we = 1'b0;
        tick();
        check("ovf_sticky", 32'(pio_ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(pio_ovf), 32'd0);
        x0 = xfers;
        fb_if.fb_ready = 1'b1;
        repeat (5) tick();
        check("ovf_drain_count", 32'(xfers - x0), 32'd2);
        check("final_sb_empty", 32'(q.size()), 32'd0);
        check("ovf_stays_clear", 32'(pio_ovf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
